// File: rtl/dm_resp.sv
// Data-memory responder: three-state load/store engine with lane stores and load extension.
// DM_MISALIGN_TRAP_EN: fault misaligned halfword/word accesses instead of force-aligning them.
module dm_resp #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic          accept;
    logic          wr_q;
    logic [2:0]    type_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd_q;
    logic          ld_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    logic          is_word;
    logic          is_half;
    logic          is_byte;
    logic          bad_type;
    logic          fault;
    logic [AW+1:0] ea;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ext;
    logic          unused_addr;

    assign unused_addr = ^addr[31:AW+2];

    always_comb begin
        is_word  = (type_q == 3'd0);
        is_half  = (type_q == 3'd1) || (type_q == 3'd2);
        is_byte  = (type_q == 3'd3) || (type_q == 3'd4);
        bad_type = (type_q > 3'd4);
        ea       = addr_q;
`ifdef DM_MISALIGN_TRAP_EN
        fault = bad_type
              | (is_half & addr_q[0])
              | (is_word & (|addr_q[1:0]));
`else
        fault = bad_type;
        if (is_half) ea[0] = 1'b0;
        if (is_word) ea[1:0] = 2'b00;
`endif
    end

    always_comb begin
        be    = 4'b0000;
        wlane = {4{wdata_q[7:0]}};
        unique case (1'b1)
            is_word: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
            is_half: begin
                be    = ea[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            is_byte: be = 4'b0001 << ea[1:0];
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        bsel = rd_q[{ea[1:0], 3'b000} +: 8];
        hsel = rd_q[{ea[1], 4'b0000} +: 16];
        unique case (type_q)
            3'd0:    ext = rd_q;
            3'd1:    ext = {{16{hsel[15]}}, hsel};
            3'd2:    ext = {16'h0000, hsel};
            3'd3:    ext = {{24{bsel[7]}}, bsel};
            3'd4:    ext = {24'h000000, bsel};
            default: ext = 32'h0;
        endcase
    end

    // Array has no reset; a reset during ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (state == ACCESS) begin
            rd_q <= mem[ea[AW+1:2]];
            if (rstn && wr_q && !fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[ea[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            ld_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q    <= mem_write;
                type_q  <= dm_type;
                addr_q  <= addr[AW+1:0];
                wdata_q <= wdata;
            end
            if (state == ACCESS) begin
                ld_q  <= !wr_q && !fault;
                err_q <= fault;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rdata     = 32'h0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = rstn;
                accept    = req_valid & rstn;
                if (accept) state_nxt = ACCESS;
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rdata     = ld_q ? ext : 32'h0;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_resp.sv
// Scoreboard bench for dm_resp: directed loads/stores, reset abort, back-to-back requests.
// Expected values follow DM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_dm_resp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        mem_write;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    localparam logic [2:0] LW  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LHU = 3'd2;
    localparam logic [2:0] LB  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;

`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    dm_resp #(.DEPTH(128)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_write (mem_write),
        .dm_type   (dm_type),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every response, idle outputs must be zero.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {err, rdata}, 33'h1_dead_beef);
            end else begin
                chk("rsp", {err, rdata}, exp_q.pop_front());
            end
        end else begin
            chk("idle_zero", {err, rdata}, 33'h0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) chk("ready_timeout", {32'h0, req_ready}, 33'h1);
    endtask

    task automatic xfer(input logic w, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee);
        wait_ready();
        exp_q.push_back({ee, er});
        req_valid = 1'b1;
        mem_write = w;
        dm_type   = t;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_write = ~w;
        dm_type   = 3'd7;
        addr      = ~a;
        wdata     = 32'hffff_ffff;
        @(negedge clk);
        chk("lat_access", {32'h0, rsp_valid}, 33'h0);
        @(negedge clk);
        chk("lat_resp", {32'h0, rsp_valid}, 33'h1);
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        mem_write = 1'b0;
        dm_type   = 3'd0;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {32'h0, req_ready}, 33'h0);
        chk("rst_valid", {32'h0, rsp_valid}, 33'h0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", {32'h0, req_ready}, 33'h1);

        xfer(1, LW,  32'h10,  32'h8765_4321, 32'h0,         0);
        xfer(0, LW,  32'h10,  32'h0,         32'h8765_4321, 0);
        xfer(1, LB,  32'h11,  32'h1234_56f0, 32'h0,         0);
        xfer(0, LB,  32'h11,  32'h0,         32'hffff_fff0, 0);
        xfer(0, LBU, 32'h11,  32'h0,         32'h0000_00f0, 0);
        xfer(0, LW,  32'h10,  32'h0,         32'h8765_f021, 0);
        xfer(0, LH,  32'h12,  32'h0,         32'hffff_8765, 0);
        xfer(0, LHU, 32'h12,  32'h0,         32'h0000_8765, 0);
        xfer(0, LW,  32'h210, 32'h0,         32'h8765_f021, 0);
        xfer(0, LW,  32'h13,  32'h0,         TRAP ? 32'h0 : 32'h8765_f021, TRAP);
        xfer(0, 3'd7, 32'h10, 32'h0,         32'h0,         1);
        xfer(1, 3'd5, 32'h10, 32'h0,         32'h0,         1);
        xfer(0, LW,  32'h10,  32'h0,         32'h8765_f021, 0);

        xfer(1, LW,  32'h14,  32'h1122_3344, 32'h0,         0);
        xfer(1, LH,  32'h16,  32'h5555_beef, 32'h0,         0);
        xfer(0, LW,  32'h14,  32'h0,         32'hbeef_3344, 0);
        xfer(0, LHU, 32'h14,  32'h0,         32'h0000_3344, 0);
        xfer(0, LH,  32'h15,  32'h0,         TRAP ? 32'h0 : 32'h0000_3344, TRAP);
        xfer(0, LB,  32'h17,  32'h0,         32'hffff_ffbe, 0);
        xfer(0, LBU, 32'h14,  32'h0,         32'h0000_0044, 0);

        // Reset during ACCESS must drop the store and its response.
        xfer(1, LW,  32'h20,  32'haaaa_aaaa, 32'h0,         0);
        wait_ready();
        req_valid = 1'b1;
        mem_write = 1'b1;
        dm_type   = LW;
        addr      = 32'h20;
        wdata     = 32'h5555_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_ready_low", {32'h0, req_ready}, 33'h0);
        repeat (2) @(negedge clk);
        chk("abort_no_rsp", {32'h0, rsp_valid}, 33'h0);
        rstn = 1'b1;
        #1;
        chk("abort_ready_high", {32'h0, req_ready}, 33'h1);
        xfer(0, LW,  32'h20,  32'h0,         32'haaaa_aaaa, 0);

        // Continuous req_valid: one accept every third cycle.
        wait_ready();
        repeat (3) exp_q.push_back({1'b0, 32'h8765_f021});
        req_valid = 1'b1;
        mem_write = 1'b0;
        dm_type   = LW;
        addr      = 32'h10;
        for (int k = 0; k < 9; k++) begin
            chk("ready_pattern", {32'h0, req_ready}, (k % 3 == 0) ? 33'h1 : 33'h0);
            if (k == 8) req_valid = 1'b0;
            @(negedge clk);
        end

        xfer(1, LW,  32'h30,  32'h0bad_f00d, 32'h0,         0);
        xfer(0, LW,  32'h30,  32'h0,         32'h0bad_f00d, 0);

        repeat (4) @(negedge clk);
        chk("drain", {1'b0, 32'(exp_q.size())}, 33'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
